// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the lot top level and the gate controller.
// The lot side drives sensors, the RFID tag and whitelist writes; the controller drives LEDs and status.
interface parking_gate_ctrl_if #(
   parameter int CNT_W = 4,
   parameter int TAG_W = 32,
   parameter int IDX_W = 2
);
   logic             sensor_entrance;
   logic             sensor_exit;
   logic [TAG_W-1:0] rfid_tag;
   logic             tag_wr_en;
   logic [IDX_W-1:0] tag_wr_idx;
   logic [TAG_W-1:0] tag_wr_data;
   logic             tag_wr_valid;
   logic             GREEN_LED;
   logic             RED_LED;
   logic [CNT_W-1:0] countcar;
   logic [2:0]       indicator;
   logic             full;
   logic [7:0]       denied_cnt;

   modport master (
      output sensor_entrance, sensor_exit, rfid_tag,
      output tag_wr_en, tag_wr_idx, tag_wr_data, tag_wr_valid,
      input  GREEN_LED, RED_LED, countcar, indicator, full, denied_cnt
   );

   modport slave (
      input  sensor_entrance, sensor_exit, rfid_tag,
      input  tag_wr_en, tag_wr_idx, tag_wr_data, tag_wr_valid,
      output GREEN_LED, RED_LED, countcar, indicator, full, denied_cnt
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking gate controller: RFID whitelist, capacity limit, timed gate hold,
// one-deep queuing of entrance/exit events and a saturating refusal counter.
module parking_gate_ctrl #(
   parameter int                 CAPACITY    = 8,
   parameter int                 CNT_W       = 4,
   parameter int                 TAG_W       = 32,
   parameter int                 NUM_TAGS    = 4,
   parameter int                 IDX_W       = 2,
   parameter logic [TAG_W-1:0]   RESET_TAG   = 32'h12345678,
   parameter int                 HOLD_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   parking_gate_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, CHECK, OPEN_IN, OPEN_OUT, DENY} state_e;
   typedef enum logic [1:0] {R_BAD_TAG, R_FULL, R_UNDERFLOW} reason_e;

   localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CAP       = CNT_W'(CAPACITY);

   state_e              state_q, state_d;
   reason_e             reason_q, reason_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [7:0]          denied_q, denied_d;
   logic                entSamp_q, entPrev_q, extSamp_q, extPrev_q;
   logic                entPend_q, entPend_d, extPend_q, extPend_d;
   logic [TAG_W-1:0]    tag_q [NUM_TAGS];
   logic [NUM_TAGS-1:0] valid_q;
   logic                tagMatch;
   logic                entService, extService, denyEnter;
   logic                entEvent, extEvent;

   // Events come from two registered samples, so an edge is seen one cycle after it is sampled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entSamp_q <= 1'b0;
         entPrev_q <= 1'b0;
         extSamp_q <= 1'b0;
         extPrev_q <= 1'b0;
         entPend_q <= 1'b0;
         extPend_q <= 1'b0;
      end else begin
         entSamp_q <= bus.sensor_entrance;
         entPrev_q <= entSamp_q;
         extSamp_q <= bus.sensor_exit;
         extPrev_q <= extSamp_q;
         entPend_q <= entPend_d;
         extPend_q <= extPend_d;
      end
   end

   assign entEvent  = entSamp_q & ~entPrev_q;
   assign extEvent  = extSamp_q & ~extPrev_q;
   assign entPend_d = entPend_q ? ~entService : entEvent;
   assign extPend_d = extPend_q ? ~extService : extEvent;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            tag_q[i] <= (i == 0) ? RESET_TAG : '0;
         end
         valid_q <= NUM_TAGS'(1);
      end else if (bus.tag_wr_en && (int'(bus.tag_wr_idx) < NUM_TAGS)) begin
         tag_q[bus.tag_wr_idx]   <= bus.tag_wr_data;
         valid_q[bus.tag_wr_idx] <= bus.tag_wr_valid;
      end
   end

   // Lookup reads the registered whitelist, so a same-cycle write is not yet visible.
   always_comb begin
      tagMatch = 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (valid_q[i] && (tag_q[i] == bus.rfid_tag)) begin
            tagMatch = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         reason_q <= R_BAD_TAG;
         hold_q   <= '0;
         count_q  <= '0;
         denied_q <= '0;
      end else begin
         state_q  <= state_d;
         reason_q <= reason_d;
         hold_q   <= hold_d;
         count_q  <= count_d;
         denied_q <= denied_d;
      end
   end

   // An exit with an empty lot is refused straight from IDLE so the green LED never flickers.
   always_comb begin
      state_d    = state_q;
      reason_d   = reason_q;
      hold_d     = hold_q;
      count_d    = count_q;
      denyEnter  = 1'b0;
      entService = 1'b0;
      extService = 1'b0;
      case (state_q)
         IDLE: begin
            if (extPend_q) begin
               extService = 1'b1;
               hold_d     = HOLD_LAST;
               if (count_q == '0) begin
                  state_d   = DENY;
                  reason_d  = R_UNDERFLOW;
                  denyEnter = 1'b1;
               end else begin
                  state_d = OPEN_OUT;
                  count_d = count_q - CNT_W'(1);
               end
            end else if (entPend_q) begin
               entService = 1'b1;
               state_d    = CHECK;
            end
         end
         CHECK: begin
            hold_d = HOLD_LAST;
            if (tagMatch && (count_q < CAP)) begin
               state_d = OPEN_IN;
               count_d = count_q + CNT_W'(1);
            end else begin
               state_d   = DENY;
               reason_d  = tagMatch ? R_FULL : R_BAD_TAG;
               denyEnter = 1'b1;
            end
         end
         OPEN_IN, OPEN_OUT, DENY: begin
            if (hold_q == '0) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      denied_d = (denyEnter && (denied_q != 8'hFF)) ? denied_q + 8'd1 : denied_q;
   end

   always_comb begin
      bus.GREEN_LED  = (state_q == OPEN_IN) || (state_q == OPEN_OUT);
      bus.RED_LED    = (state_q == DENY);
      bus.countcar   = count_q;
      bus.full       = (count_q == CAP);
      bus.denied_cnt = denied_q;
      case (state_q)
         IDLE:     bus.indicator = 3'd0;
         CHECK:    bus.indicator = 3'd1;
         OPEN_IN:  bus.indicator = 3'd2;
         OPEN_OUT: bus.indicator = 3'd3;
         DENY: begin
            case (reason_q)
               R_FULL:      bus.indicator = 3'd5;
               R_UNDERFLOW: bus.indicator = 3'd6;
               default:     bus.indicator = 3'd4;
            endcase
         end
         default:  bus.indicator = 3'd7;
      endcase
   end

endmodule
